// File: rtl/branch_predict_unit_if.sv
// Fetch/decode-side signal bundle of the branch unit.
// master = pipeline that drives PCs and operands, slave = the branch unit.
interface branch_predict_unit_if #(
  parameter int PERF_W = 32
);
  logic [31:0]       F_pc;
  logic              F_isBranch;
  logic              F_predTaken;
  logic              D_valid;
  logic              D_stall;
  logic [31:0]       D_pc;
  logic [31:0]       D_rs;
  logic [31:0]       D_rt;
  logic [4:0]        D_BranchOp;
  logic              D_Judge;
  logic              D_predTaken;
  logic              D_taken;
  logic              D_mispredict;
  logic [PERF_W-1:0] branch_cnt;
  logic [PERF_W-1:0] miss_cnt;

  modport master (
    output F_pc, F_isBranch, D_valid, D_stall, D_pc, D_rs, D_rt,
           D_BranchOp, D_Judge, D_predTaken,
    input  F_predTaken, D_taken, D_mispredict, branch_cnt, miss_cnt
  );

  modport slave (
    input  F_pc, F_isBranch, D_valid, D_stall, D_pc, D_rs, D_rt,
           D_BranchOp, D_Judge, D_predTaken,
    output F_predTaken, D_taken, D_mispredict, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch unit: predicts in F from a PC-indexed table of saturating counters,
// resolves conditional branches in D, and keeps saturating counts of resolved
// branches and mispredictions. The table is untagged, so aliasing PCs share an entry.
module branch_predict_unit #(
  parameter int INDEX_W = 6,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 32
) (
  input  logic clk,
  input  logic reset,
  branch_predict_unit_if.slave bus
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam logic [CNT_W-1:0] WEAK_NT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [CNT_W-1:0]   table_q [ENTRIES];
  logic [CNT_W-1:0]   entry_d;
  logic [PERF_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [PERF_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] f_idx;
  logic [INDEX_W-1:0] d_idx;
  logic [CNT_W-1:0]   d_entry;
  logic               op_known;
  logic               cond;
  logic               taken;
  logic               resolve;
  logic               mispredict;
  logic               rs_neg;
  logic               rs_zero;

  assign f_idx   = bus.F_pc[INDEX_W+1:2];
  assign d_idx   = bus.D_pc[INDEX_W+1:2];
  assign d_entry = table_q[d_idx];
  assign rs_neg  = bus.D_rs[31];
  assign rs_zero = (bus.D_rs == 32'd0);

  // Branch condition evaluation; operands are treated as signed 32-bit values.
  always_comb begin
    cond     = 1'b0;
    op_known = 1'b1;
    case (bus.D_BranchOp)
      5'd1:    cond = bus.D_Judge ? !rs_neg : rs_neg;
      5'd2:    cond = (bus.D_rs == bus.D_rt);
      5'd3:    cond = (bus.D_rs != bus.D_rt);
      5'd4:    cond = rs_neg | rs_zero;
      5'd5:    cond = !rs_neg & !rs_zero;
      default: op_known = 1'b0;
    endcase
  end

  assign taken      = bus.D_valid & cond;
  assign resolve    = bus.D_valid & !bus.D_stall & op_known;
  assign mispredict = resolve & (taken ^ bus.D_predTaken);

  // Next value of the resolved entry and the performance counters, all saturating.
  always_comb begin
    entry_d      = d_entry;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (taken) begin
      if (d_entry != CNT_MAX) entry_d = d_entry + 1'b1;
    end else begin
      if (d_entry != '0) entry_d = d_entry - 1'b1;
    end
    if (branch_cnt_q != PERF_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
    if (mispredict && (miss_cnt_q != PERF_MAX)) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  // Counter table: cleared to weakly-not-taken, one entry written per resolved branch.
  // No read bypass: F sees the new value only from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WEAK_NT;
    end else if (resolve) begin
      table_q[d_idx] <= entry_d;
    end
  end

  // Performance counters advance once per branch leaving D (never while stalled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else if (resolve) begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.F_predTaken  = bus.F_isBranch & table_q[f_idx][CNT_W-1];
  assign bus.D_taken      = taken;
  assign bus.D_mispredict = mispredict;
  assign bus.branch_cnt   = branch_cnt_q;
  assign bus.miss_cnt     = miss_cnt_q;
endmodule
